// File: rtl/cb_pkg.sv
// Connection-box shared definitions.
// Selector width helper, selector/mode encodings.
package cb_pkg;

  function automatic int sel_w(input int n_tracks);
    return $clog2(n_tracks + 1);
  endfunction

  localparam int   SEL_OFF   = 0;
  localparam logic MODE_COMB = 1'b0;
  localparam logic MODE_REG  = 1'b1;

endpackage

// File: rtl/cb_pin.sv
// One connection-box pin: track selector, pin flop, mode mux.
// Ports: clk, rst, in (tracks), fld (sel + mode), out (pin).
import cb_pkg::*;

module cb_pin #(
  parameter int N_TRACKS = 8,
  parameter int SEL_W    = sel_w(8)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_TRACKS-1:0] in,
  input  logic [SEL_W:0]      fld,
  output logic                out
);

  logic [SEL_W-1:0] sel;
  logic             mode;
  logic             dec;
  logic             q;

  assign sel  = fld[SEL_W-1:0];
  assign mode = fld[SEL_W];

  // sel 1..N picks in[sel-1]; off and out-of-range read 0
  always_comb begin
    dec = 1'b0;
    if (sel != SEL_W'(SEL_OFF)) begin
      for (int i = 0; i < N_TRACKS; i++) begin
        if (sel == SEL_W'(i + 1)) dec = in[i];
      end
    end
  end

  // sampled every cycle so a mode switch never shows stale data
  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else     q <= dec;
  end

  assign out = (mode == MODE_REG) ? q : dec;

endmodule

// File: rtl/cb_cfg.sv
// Connection box: serial shadow chain, atomic commit, N_PINS pins.
// Ports: clk, rst, in, out, cfg_en/in/out, cfg_commit, cfg_done/err.
import cb_pkg::*;

module cb_cfg #(
  parameter int N_TRACKS = 8,
  parameter int N_PINS   = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_TRACKS-1:0] in,
  output logic [N_PINS-1:0]   out,
  input  logic                cfg_en,
  input  logic                cfg_in,
  output logic                cfg_out,
  input  logic                cfg_commit,
  output logic                cfg_done,
  output logic                cfg_err
);

  localparam int SEL_W    = sel_w(N_TRACKS);
  localparam int FLD_W    = SEL_W + 1;
  localparam int CFG_BITS = N_PINS * FLD_W;
  localparam int CNT_W    = $clog2(CFG_BITS + 1);

  logic [CFG_BITS-1:0] shadow;
  logic [CFG_BITS-1:0] active;
  logic [CNT_W-1:0]    cnt;
  logic                full;

  assign full    = (cnt == CNT_W'(CFG_BITS));
  assign cfg_out = shadow[CFG_BITS-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow   <= '0;
      active   <= '0;
      cnt      <= '0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      if (cfg_en)
        shadow <= {shadow[CFG_BITS-2:0], cfg_in};
      if (cfg_commit && full) begin
        // pre-shift shadow is the complete frame
        active   <= shadow;
        cfg_done <= 1'b1;
        cnt      <= cfg_en ? CNT_W'(1) : '0;
      end else begin
        if (cfg_commit)
          cfg_err <= 1'b1;
        // saturate; chain keeps passing data through
        if (cfg_en && !full)
          cnt <= cnt + CNT_W'(1);
      end
    end
  end

  for (genvar p = 0; p < N_PINS; p++) begin : g_pin
    cb_pin #(
      .N_TRACKS (N_TRACKS),
      .SEL_W    (SEL_W)
    ) u_pin (
      .clk (clk),
      .rst (rst),
      .in  (in),
      .fld (active[p*FLD_W +: FLD_W]),
      .out (out[p])
    );
  end

endmodule

// File: tb/tb_cb_cfg.sv
// Directed self-checking bench for cb_cfg.
// Default geometry: 8 tracks, 6 pins, 30 config bits.
module tb_cb_cfg;

  localparam int NT = 8;
  localparam int NP = 6;
  localparam int CB = 30;

  logic          clk = 1'b0;
  logic          rst;
  logic [NT-1:0] in;
  logic [NP-1:0] out;
  logic          cfg_en;
  logic          cfg_in;
  logic          cfg_out;
  logic          cfg_commit;
  logic          cfg_done;
  logic          cfg_err;

  int checks = 0;
  int errors = 0;

  cb_cfg #(.N_TRACKS(NT), .N_PINS(NP)) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in),
    .out        (out),
    .cfg_en     (cfg_en),
    .cfg_in     (cfg_in),
    .cfg_out    (cfg_out),
    .cfg_commit (cfg_commit),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    cfg_en = 1'b1;
    cfg_in = b;
    tick();
    cfg_en = 1'b0;
    cfg_in = 1'b0;
  endtask

  // sends v[CB-1] first, n bits total
  task automatic shift_vec(input logic [CB-1:0] v, input int n);
    for (int i = 0; i < n; i++) shift_bit(v[CB-1-i]);
  endtask

  task automatic pulse_commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in  = 8'hFF;
    tick();
    tick();
    checks++;
    if (out !== 6'b0 || cfg_out !== 1'b0 || cfg_done !== 1'b0 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: out=%b cfg_out=%b done=%b err=%b, want 0/0/0/0",
               out, cfg_out, cfg_done, cfg_err);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (out !== 6'b0) begin
      errors++;
      $display("FAIL reset_release: out=%b want 000000", out);
    end
  endtask

  task automatic test_comb();
    in = 8'h00;
    shift_vec(30'h3, CB);
    pulse_commit();
    checks++;
    if (cfg_done !== 1'b1 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL comb_commit: done=%b err=%b want 1/0", cfg_done, cfg_err);
    end
    in = 8'h04;
    #1;
    checks++;
    if (out !== 6'b000001) begin
      errors++;
      $display("FAIL comb_hi: out=%b want 000001", out);
    end
    tick();
    checks++;
    if (cfg_done !== 1'b0) begin
      errors++;
      $display("FAIL comb_done_pulse: done=%b want 0", cfg_done);
    end
    in = 8'h00;
    #1;
    checks++;
    if (out !== 6'b000000) begin
      errors++;
      $display("FAIL comb_lo: out=%b want 000000", out);
    end
    in = 8'hFB;
    #1;
    checks++;
    if (out !== 6'b000000) begin
      errors++;
      $display("FAIL comb_other_tracks: out=%b want 000000", out);
    end
    in = 8'h00;
  endtask

  task automatic test_registered();
    // pin1: mode=1 sel=8
    shift_vec(30'h300, CB);
    pulse_commit();
    checks++;
    if (cfg_done !== 1'b1) begin
      errors++;
      $display("FAIL reg_commit: done=%b want 1", cfg_done);
    end
    tick();
    in = 8'h80;
    #1;
    checks++;
    if (out[1] !== 1'b0) begin
      errors++;
      $display("FAIL reg_t: out[1]=%b want 0", out[1]);
    end
    tick();
    checks++;
    if (out[1] !== 1'b1) begin
      errors++;
      $display("FAIL reg_t1: out[1]=%b want 1", out[1]);
    end
    in = 8'h00;
    #1;
    checks++;
    if (out[1] !== 1'b1) begin
      errors++;
      $display("FAIL reg_hold: out[1]=%b want 1", out[1]);
    end
    tick();
    checks++;
    if (out[1] !== 1'b0) begin
      errors++;
      $display("FAIL reg_fall: out[1]=%b want 0", out[1]);
    end
  endtask

  task automatic test_short_load();
    shift_vec(30'h1, CB - 1);
    pulse_commit();
    checks++;
    if (cfg_err !== 1'b1 || cfg_done !== 1'b0) begin
      errors++;
      $display("FAIL short_commit: done=%b err=%b want 0/1", cfg_done, cfg_err);
    end
    in = 8'h81;
    tick();
    checks++;
    if (out !== 6'b000010 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL short_active_kept: out=%b err=%b want 000010/0", out, cfg_err);
    end
    shift_bit(1'b1);
    pulse_commit();
    checks++;
    if (cfg_done !== 1'b1 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL short_finish: done=%b err=%b want 1/0", cfg_done, cfg_err);
    end
    in = 8'h01;
    #1;
    checks++;
    if (out !== 6'b000001) begin
      errors++;
      $display("FAIL short_new_cfg: out=%b want 000001", out);
    end
  endtask

  task automatic test_out_of_range();
    // pin2 sel=9, pin3 sel=15, pin4 sel=8 as a live reference
    shift_vec((30'd9 << 10) | (30'd15 << 15) | (30'd8 << 20), CB);
    pulse_commit();
    in = 8'hFF;
    #1;
    checks++;
    if (out !== 6'b010000) begin
      errors++;
      $display("FAIL oor: out=%b want 010000", out);
    end
  endtask

  task automatic test_chain();
    logic [CB-1:0] old;
    logic [34:0]   pat;
    logic          exp;
    int            bad;
    old = (30'd9 << 10) | (30'd15 << 15) | (30'd8 << 20);
    pat = 35'h5_A3C9_6E1B;
    bad = 0;
    for (int n = 0; n < 35; n++) begin
      exp = (n < CB) ? old[CB-1-n] : pat[34-(n-CB)];
      checks++;
      if (cfg_out !== exp) begin
        errors++;
        bad++;
        if (bad < 4)
          $display("FAIL chain_out[%0d]: cfg_out=%b want %b", n, cfg_out, exp);
      end
      shift_bit(pat[34-n]);
    end
  endtask

  task automatic test_reset_mid_load();
    shift_vec(30'h2AAA_AAAA, 12);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (cfg_out !== 1'b0 || out !== 6'b0) begin
      errors++;
      $display("FAIL mid_reset: cfg_out=%b out=%b want 0/000000", cfg_out, out);
    end
    shift_vec(30'h3FFF_FFFF, 20);
    pulse_commit();
    checks++;
    if (cfg_err !== 1'b1 || cfg_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_commit: done=%b err=%b want 0/1", cfg_done, cfg_err);
    end
    tick();
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_err_pulse: err=%b want 0", cfg_err);
    end
  endtask

  initial begin
    rst        = 1'b1;
    in         = '0;
    cfg_en     = 1'b0;
    cfg_in     = 1'b0;
    cfg_commit = 1'b0;
    test_reset();
    test_comb();
    test_registered();
    test_short_load();
    test_out_of_range();
    test_chain();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cb_cfg.md
Name: cb_cfg

Overview:
Parametrised connection box for the FPGA routing fabric. Connects N_TRACKS routing tracks to N_PINS logic-block input pins through per-pin selectors. Configuration is loaded serially through a daisy-chainable shadow shift register and committed atomically to an active configuration register. Each pin can be configured as combinational or registered.

Parameters:
N_TRACKS, 8, number of routing-track inputs
N_PINS, 6, number of output pins
SEL_W, $clog2(N_TRACKS+1), selector field width per pin (derived; do not override)
FLD_W, SEL_W+1, config bits per pin: selector plus mode bit (derived)
CFG_BITS, N_PINS*FLD_W, total configuration length (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in  in  N_TRACKS  routing tracks
out  out  N_PINS  pin outputs
cfg_en  in  1  shift enable for the config chain
cfg_in  in  1  serial config data in
cfg_out  out  1  serial config data out, to next block in the chain
cfg_commit  in  1  single-cycle request to copy shadow to active
cfg_done  out  1  1-cycle pulse: commit accepted
cfg_err  out  1  1-cycle pulse: commit rejected (incomplete load)

Behaviour:
- One clock, synchronous active-high reset. On reset: shadow=0, active=0, bit counter=0, pin flops=0, cfg_out=0, cfg_done=0, cfg_err=0. out=0 follows from active=0.
- Shift: when cfg_en=1, shadow <= {shadow[CFG_BITS-2:0], cfg_in}. cfg_out = shadow[CFG_BITS-1], which is registered. Data is sent MSB first. The first bit shifted ends at bit CFG_BITS-1.
- Field layout: pin p occupies shadow/active [p*FLD_W +: FLD_W]. Bits [SEL_W-1:0] hold the selector; bit SEL_W is the mode bit (1 = registered).
- Bit counter: width $clog2(CFG_BITS+1). Increments on each cfg_en cycle and saturates at CFG_BITS. Shifting continues after saturation so the chain passes data through.
- Commit, when cfg_commit=1:
  - If counter==CFG_BITS: active <= shadow (the pre-shift value of that cycle). cfg_done=1 next cycle. Counter <= cfg_en ? 1 : 0.
  - Otherwise: cfg_err=1 next cycle. Active is unchanged. Counter follows normal shift rules.
  - Commit never blocks shifting.
- Selector decode per pin, with s = sel field:
  - s=0 gives a constant 0 (disconnected).
  - 1<=s<=N_TRACKS gives in[s-1].
  - s>N_TRACKS gives a constant 0.
- Mode:
  - mode=0: out[p] is the combinational decode of the current in. Latency 0.
  - mode=1: out[p] = pin flop. Latency 1 cycle.
  - The pin flop samples the decoded value every cycle regardless of mode. A comb-to-registered switch therefore never exposes stale data older than 1 cycle.
- Active takes effect in the cycle after the commit edge, the same cycle cfg_done is high.
- Reset mid-load: everything clears. A fresh load of CFG_BITS bits is required before a commit succeeds.
- cfg_done and cfg_err are mutually exclusive and never asserted for 2 consecutive cycles by a single commit pulse.

Decomposition:
- Package cb_pkg:
  - function sel_w(n_tracks) returning $clog2(n+1)
  - constant SEL_OFF=0
  - mode bit encodings MODE_COMB=0, MODE_REG=1
- Sub-module cb_pin, instantiated N_PINS times: selector decode, pin flop, output mode mux.
- cb_cfg owns the shadow chain, counter, active register and the commit/done/err logic.

Test Plan:
Defaults throughout: N_TRACKS=8, N_PINS=6, SEL_W=4, FLD_W=5, CFG_BITS=30.
- Reset: assert rst for 2 cycles with in=8'hFF -> out=6'b0, cfg_out=0, cfg_done=0, cfg_err=0.
- Full load, combinational: shift 30 bits setting pin0 sel=3 mode=0 and all other fields 0, then pulse commit -> cfg_done high for 1 cycle. Then in=8'h04 gives out[0]=1 in the same cycle; in=8'h00 gives out[0]=0.
- Registered mode: load pin1 sel=8 mode=1 and commit. Raise in[7] at cycle t -> out[1] rises at t+1, not at t.
- Short load: 29 shifts then commit -> cfg_err pulses, cfg_done stays 0, out and active unchanged. One more shift then commit -> cfg_done pulses.
- Out-of-range selector: pin2 sel=9 and pin3 sel=15, with in=8'hFF -> out[2]=0 and out[3]=0.
- Chaining and reset mid-load:
  - Shift 35 bits; cfg_out emits bit k at shift cycle k+30, registered.
  - Separately, assert rst after 12 shifts, then shift 20 and commit -> cfg_err.
